dcache_direct_mapped: RTL

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's MEM stage and the word-wide data memory port. It serves loads from a 4-line × 4-word array and fills a whole block from memory on a read miss. It passes every store to memory, and updates the array too when the store hits. While any memory transaction is in flight it holds the pipeline with `cache_stall` and exposes hit/miss counters for performance measurement.

---
 rtl/dcache_direct_mapped.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache: 4 lines x 4 words.
// Loads that hit return data combinationally; read misses fill the whole block
// word by word from memory; every store goes to memory and updates the array on hit.
//
// Handshake: the pipeline holds cache_read/cache_write and data_address/write_data
// stable until a cycle with cache_stall == 0; that cycle completes the request and
// the pipeline advances on the following rising edge. The memory side has no
// ready signal: each single-word access occupies exactly MEM_LATENCY cycles, and
// read data on mem_data is captured on the last of those cycles.
module dcache_direct_mapped #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] data_address,
    input  logic [WORD_SIZE-1:0] write_data,
    input  logic                 cache_read,
    input  logic                 cache_write,
    output logic [WORD_SIZE-1:0] cache_data,
    output logic                 cache_stall,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    inout  wire  [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count,
    output logic [1:0]           fsm_state
);

    localparam int TAG_W = WORD_SIZE - 4;
    localparam int BLK_W = WORD_SIZE - 2;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Line storage: valid bit, tag, and four data words per line.
    logic [3:0]             valid_q;
    logic [TAG_W-1:0]       tag_q  [0:3];
    logic [WORD_SIZE-1:0]   data_q [0:15];

    // Miss bookkeeping: block number being filled, word position, latency count.
    logic [BLK_W-1:0]       base_q;
    logic [1:0]             word_cnt_q;
    logic [LAT_W-1:0]       lat_cnt_q;

    logic [1:0]             req_off;
    logic [1:0]             req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic                   hit;
    logic                   lat_last;

    assign req_off  = data_address[1:0];
    assign req_idx  = data_address[3:2];
    assign req_tag  = data_address[WORD_SIZE-1:4];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lat_last = (lat_cnt_q == LAT_W'(MEM_LATENCY - 1));

    // Loads always see the array word at the requested address.
    assign cache_data = data_q[{req_idx, req_off}];

    // Store data is driven onto the shared bus only while writing.
    assign mem_data = mem_write ? write_data : {WORD_SIZE{1'bz}};

    assign fsm_state = state_q;

    // State register; reset aborts any in-flight memory transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode plus stall and memory strobes.
    always_comb begin
        state_d     = state_q;
        cache_stall = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        case (state_q)
            S_IDLE: begin
                if (cache_read) begin
                    if (!hit) begin
                        cache_stall = 1'b1;
                        state_d     = S_FILL;
                    end
                end else if (cache_write) begin
                    cache_stall = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_FILL: begin
                cache_stall = 1'b1;
                mem_read    = 1'b1;
                mem_address = {base_q, word_cnt_q};
                if (lat_last && (word_cnt_q == 2'd3)) state_d = S_DONE;
            end
            S_WRITE: begin
                cache_stall = 1'b1;
                mem_write   = 1'b1;
                mem_address = data_address;
                if (lat_last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid/tag, performance counters and fill/write sequencing counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            base_q     <= '0;
            word_cnt_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cache_read) begin
                        if (hit) begin
                            hit_count <= hit_count + 1'b1;
                        end else begin
                            miss_count <= miss_count + 1'b1;
                            base_q     <= data_address[WORD_SIZE-1:2];
                            word_cnt_q <= '0;
                            lat_cnt_q  <= '0;
                        end
                    end else if (cache_write) begin
                        if (hit) hit_count  <= hit_count + 1'b1;
                        else     miss_count <= miss_count + 1'b1;
                        lat_cnt_q <= '0;
                    end
                end
                S_FILL: begin
                    if (lat_last) begin
                        lat_cnt_q  <= '0;
                        word_cnt_q <= word_cnt_q + 2'd1;
                        // Line becomes valid only once its last word has arrived.
                        if (word_cnt_q == 2'd3) begin
                            valid_q[base_q[1:0]] <= 1'b1;
                            tag_q[base_q[1:0]]   <= base_q[BLK_W-1:2];
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    lat_cnt_q <= lat_last ? '0 : lat_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Data array: store-hit update in IDLE, fill capture on each word's last latency cycle.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if ((state_q == S_IDLE) && !cache_read && cache_write && hit)
                data_q[{req_idx, req_off}] <= write_data;
            else if ((state_q == S_FILL) && lat_last)
                data_q[{base_q[1:0], word_cnt_q}] <= mem_data;
        end
    end

endmodule
